// File: rtl/mem_loader.sv
// Stream-to-SRAM loader: parses MAGIC/ADDR/COUNT/DATA frames from a byte stream
// and issues one bus write per received little-endian word.
//
// state   | meaning
// S_IDLE  | waiting for MAGIC, other bytes dropped
// S_ADDR  | collecting 4 address bytes
// S_COUNT | collecting 4 word-count bytes
// S_DATA  | collecting 4 bytes of the next data word
// S_WRITE | one-cycle bus write (suppressed when out of range)
// S_DONE  | one-cycle completion pulse
module mem_loader #(
  parameter logic [7:0]  MAGIC      = 8'hA5,
  parameter int unsigned ADDR_LIMIT = 65536,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data,
  output logic        bus_we,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] checksum
);

  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [31:0] LP_LIMIT = 32'(ADDR_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_COUNT, S_DATA, S_WRITE, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_rem;
  logic [31:0] r_word;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_data;
  logic [31:0] r_checksum;
  logic [1:0]  r_bcnt;
  logic [TW-1:0] r_tmo;
  logic        r_error;

  logic        w_accept;
  logic        w_last_byte;
  logic        w_counting;
  logic        w_tmo_hit;
  logic        w_in_range;
  logic [31:0] w_shift_addr;
  logic [31:0] w_shift_rem;
  logic [31:0] w_shift_word;

  // Bytes shift in from the top so the first byte ends up in bits [7:0].
  assign w_shift_addr = {in_data, r_addr[31:8]};
  assign w_shift_rem  = {in_data, r_rem[31:8]};
  assign w_shift_word = {in_data, r_word[31:8]};

  assign w_accept    = in_valid & in_ready;
  assign w_last_byte = w_accept & (r_bcnt == 2'd3);
  assign w_counting  = (r_state == S_ADDR) | (r_state == S_COUNT) | (r_state == S_DATA);
  assign w_tmo_hit   = w_counting & ~w_accept & (r_tmo == TW'(1));
  assign w_in_range  = r_addr < LP_LIMIT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && in_data == MAGIC) w_next = S_ADDR;
      S_ADDR: begin
        if (w_tmo_hit)        w_next = S_IDLE;
        else if (w_last_byte) w_next = S_COUNT;
      end
      S_COUNT: begin
        if (w_tmo_hit)        w_next = S_IDLE;
        else if (w_last_byte) w_next = (w_shift_rem == 32'd0) ? S_DONE : S_DATA;
      end
      S_DATA: begin
        if (w_tmo_hit)        w_next = S_IDLE;
        else if (w_last_byte) w_next = S_WRITE;
      end
      S_WRITE: w_next = (r_rem == 32'd1) ? S_DONE : S_DATA;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    bus_we   = 1'b0;
    case (r_state)
      S_ADDR, S_COUNT, S_DATA: busy = 1'b1;
      S_WRITE: begin
        in_ready = 1'b0;
        busy     = 1'b1;
        bus_we   = w_in_range;
      end
      S_DONE: begin
        in_ready = 1'b0;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_rem      <= '0;
      r_word     <= '0;
      r_bus_addr <= '0;
      r_bus_data <= '0;
      r_checksum <= '0;
      r_bcnt     <= '0;
      r_tmo      <= TW'(TIMEOUT);
      r_error    <= 1'b0;
    end else begin
      if (!w_counting || w_tmo_hit) r_bcnt <= '0;
      else if (w_accept)            r_bcnt <= r_bcnt + 2'd1;

      if (!w_counting || w_accept) r_tmo <= TW'(TIMEOUT);
      else                         r_tmo <= r_tmo - TW'(1);

      if (w_tmo_hit) r_error <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_accept && in_data == MAGIC) begin
            r_error    <= 1'b0;
            r_checksum <= '0;
          end
        end
        S_ADDR:  if (w_accept) r_addr <= w_shift_addr;
        S_COUNT: if (w_accept) r_rem  <= w_shift_rem;
        S_DATA: begin
          if (w_accept) r_word <= w_shift_word;
          // Bus registers load one edge early so they are stable during WRITE.
          if (w_last_byte) begin
            r_checksum <= r_checksum ^ w_shift_word;
            r_bus_addr <= r_addr;
            r_bus_data <= w_shift_word;
          end
        end
        S_WRITE: begin
          r_addr <= r_addr + 32'd1;
          r_rem  <= r_rem - 32'd1;
          if (!w_in_range) r_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus_addr = r_bus_addr;
  assign bus_data = r_bus_data;
  assign error    = r_error;
  assign checksum = r_checksum;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed frames plus randomized frames
// compared against a frame-level model of expected writes, checksum and error.
module tb_mem_loader;

  localparam int          TMO   = 40;
  localparam logic [31:0] LIMIT = 32'd65536;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_we;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  logic [31:0] act_a[$];
  logic [31:0] act_d[$];
  logic [31:0] pre_words[$];

  mem_loader #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_we(bus_we), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus_we) begin
        act_a.push_back(bus_addr);
        act_d.push_back(bus_data);
        check("ready_in_write", {31'd0, in_ready}, 32'd0);
      end
      if (done) begin
        done_cnt++;
        check("ready_in_done", {31'd0, in_ready}, 32'd0);
      end
      if (busy) busy_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  task automatic run_frame(input logic [31:0] a, input logic [31:0] n, input bit gaps);
    logic [31:0] w;
    logic [31:0] ea;
    logic [31:0] ck;
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    int d0;
    bit eerr;
    act_a.delete();
    act_d.delete();
    d0 = done_cnt;
    ck = '0;
    eerr = 1'b0;
    send_byte(8'hA5, gaps);
    send_word(a, gaps);
    send_word(n, gaps);
    for (int i = 0; i < int'(n); i++) begin
      w  = (pre_words.size() > 0) ? pre_words.pop_front() : $urandom;
      ea = a + 32'(i);
      ck ^= w;
      send_word(w, gaps);
      @(negedge clk);
      in_valid = 1'b0;
      if (ea < LIMIT) begin
        exp_a.push_back(ea);
        exp_d.push_back(w);
        check("lat_we", {31'd0, bus_we}, 32'd1);
        check("lat_addr", bus_addr, ea);
        check("lat_data", bus_data, w);
      end else begin
        eerr = 1'b1;
        check("suppressed_we", {31'd0, bus_we}, 32'd0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("n_writes", act_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < act_a.size(); i++) begin
      check("wr_addr", act_a[i], exp_a[i]);
      check("wr_data", act_d[i], exp_d[i]);
    end
    check("done_pulses", done_cnt - d0, 32'd1);
    check("checksum", checksum, ck);
    check("error", {31'd0, error}, {31'd0, eerr});
    check("busy_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, {31'd0, bus_we}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_cksum"}, checksum, 32'd0);
    check({tag, "_addr"}, bus_addr, 32'd0);
    check({tag, "_data"}, bus_data, 32'd0);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int d0;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: two words at 0x10
    pre_words.push_back(32'h44332211);
    pre_words.push_back(32'hDDCCBBAA);
    run_frame(32'h10, 32'd2, 1'b0);
    check("t1_cksum_const", checksum, 32'h99FF99BB);

    // Garbage then empty frame: busy only during the 8 header bytes
    busy_cnt = 0;
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("garbage_busy", {31'd0, busy}, 32'd0);
    run_frame(32'h40, 32'd0, 1'b0);
    check("hdr_busy_cycles", busy_cnt, 32'd8);

    // Range boundary and address wrap
    run_frame(32'h0000FFFF, 32'd2, 1'b0);
    run_frame(32'hFFFFFFFF, 32'd2, 1'b1);

    // Timeout after two data bytes
    act_a.delete();
    act_d.delete();
    d0 = done_cnt;
    send_byte(8'hA5, 1'b0);
    send_word(32'h100, 1'b0);
    send_word(32'd3, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (TMO - 6) @(negedge clk);
    check("tmo_not_yet", {31'd0, busy}, 32'd1);
    repeat (TMO) @(negedge clk);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    check("tmo_error", {31'd0, error}, 32'd1);
    check("tmo_no_done", done_cnt - d0, 32'd0);
    check("tmo_no_we", act_a.size(), 32'd0);
    run_frame(32'h200, 32'd1, 1'b1);

    // Reset asserted while in WRITE
    d0 = done_cnt;
    send_byte(8'hA5, 1'b0);
    send_word(32'h20, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_we", {31'd0, bus_we}, 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 32'd0);
    run_frame(32'h30, 32'd2, 1'b0);

    // Back-to-back bytes with in_valid held high
    run_frame(32'h1000, 32'd5, 1'b0);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      case ($urandom_range(0, 3))
        0: a = 32'($urandom_range(0, 255));
        1: a = 32'h0000FFFE - 32'($urandom_range(0, 3));
        2: a = 32'hFFFFFFFE;
        default: a = $urandom;
      endcase
      run_frame(a, 32'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
